// File: rtl/image_test_pattern.sv
`default_nettype none
// ============================================================================
// Module   : image_test_pattern
// Purpose  : Frame-level image source that drives an image pipe bus with a
//            deterministic counter-based test pattern. It emits whole frames
//            while the downstream Request line is high, honours Ready
//            back-pressure and aborts the current frame on Cancel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   OutIS   output image spec; bus width `I_w(OutIS), data width `I_Data_w(OutIS)
//   Width   pixels per line (>= 1)
//   Height  lines per frame (>= 1)
// Ports
//   clock      in     single clock, all state updates on its rising edge
//   reset      in     asynchronous active-low reset
//   image_out  inout  packed image bus
//                     driven here : Start, Stop, Data, Valid, Error
//                     read here   : Ready, Request, Cancel
// Build option
//   IMAGE_TEST_PATTERN_FRAME_COUNT_EN
//     defined   : pixel data = (pixel index + frame count) mod 2^DW
//     undefined : pixel data = pixel index; frame counter is not built
// ----------------------------------------------------------------------------
// Bus layout (LSB first): [0] Start, [1] Stop, [2] Valid, [3] Error,
//                         [4] Ready, [5] Request, [6] Cancel, [7 +: DW] Data
// ============================================================================

`ifndef IS_DEFAULT
`define IS_DEFAULT 8
`endif
`ifndef I_w
`define I_w(IS) ((IS) + 7)
`endif
`ifndef I_Data_w
`define I_Data_w(IS) (IS)
`endif
`ifndef I_Start
`define I_Start(IS, b) b[0]
`endif
`ifndef I_Stop
`define I_Stop(IS, b) b[1]
`endif
`ifndef I_Valid
`define I_Valid(IS, b) b[2]
`endif
`ifndef I_Error
`define I_Error(IS, b) b[3]
`endif
`ifndef I_Ready
`define I_Ready(IS, b) b[4]
`endif
`ifndef I_Request
`define I_Request(IS, b) b[5]
`endif
`ifndef I_Cancel
`define I_Cancel(IS, b) b[6]
`endif
`ifndef I_Data
`define I_Data(IS, b) b[7 +: (IS)]
`endif

module image_test_pattern #(
  parameter int OutIS  = `IS_DEFAULT,
  parameter int Width  = 8,
  parameter int Height = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire [`I_w(OutIS)-1:0] image_out
);

  localparam int c_dw     = `I_Data_w(OutIS);
  localparam int c_pixels = Width * Height;
  localparam int c_pw     = (c_pixels > 1) ? $clog2(c_pixels) : 1;
  // Sum width wide enough that index + 1 + offset never overflows before
  // truncation to the data width.
  localparam int c_sw     = ((c_dw > c_pw) ? c_dw : c_pw) + 1;

  localparam logic [c_pw-1:0] c_last   = c_pw'(c_pixels - 1);
  // Index of the pixel just before the last one; only meaningful when the
  // frame has at least two pixels, otherwise never compared in RUN.
  localparam logic [c_pw-1:0] c_penult = c_pw'((c_pixels > 1) ? (c_pixels - 2) : 0);
  localparam logic            c_single = (c_pixels == 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_pw-1:0]   r_p;
  logic              r_valid;
  logic              r_start;
  logic              r_stop;
  logic [c_dw-1:0]   r_data;

  logic              w_ready;
  logic              w_request;
  logic              w_cancel;
  logic              w_transfer;
  logic              w_last;
  logic [c_dw-1:0]   w_offset;
  logic [c_sw-1:0]   w_sum;
  logic [c_dw-1:0]   w_next_data;

  // --------------------------------------------------------------------------
  // Bus access
  // --------------------------------------------------------------------------
  assign w_ready   = `I_Ready(OutIS, image_out);
  assign w_request = `I_Request(OutIS, image_out);
  assign w_cancel  = `I_Cancel(OutIS, image_out);

  assign `I_Start(OutIS, image_out) = r_start;
  assign `I_Stop(OutIS, image_out)  = r_stop;
  assign `I_Valid(OutIS, image_out) = r_valid;
  assign `I_Error(OutIS, image_out) = 1'b0;
  assign `I_Data(OutIS, image_out)  = r_data;

  assign w_transfer = r_valid & w_ready;
  assign w_last     = (r_p == c_last);

  // --------------------------------------------------------------------------
  // Optional frame counter: shifts each frame's pattern by one so dropped or
  // repeated frames become visible downstream.
  // --------------------------------------------------------------------------
`ifdef IMAGE_TEST_PATTERN_FRAME_COUNT_EN
  logic [c_dw-1:0] r_f;

  // Only a frame that completes its last transfer counts; a cancel wins over
  // a simultaneous final transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_f <= '0;
    end else if ((r_state == S_RUN) && !w_cancel && w_transfer && w_last) begin
      r_f <= r_f + c_dw'(1);
    end
  end

  assign w_offset = r_f;
`else
  assign w_offset = '0;
`endif

  assign w_sum       = c_sw'(r_p) + c_sw'(1) + c_sw'(w_offset);
  assign w_next_data = w_sum[c_dw-1:0];

  // --------------------------------------------------------------------------
  // Frame sequencer. All bus outputs are registered here, so there is no
  // combinational path from Ready/Request/Cancel to the bus.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_request && !w_cancel) begin
            r_state <= S_RUN;
            r_p     <= '0;
            r_valid <= 1'b1;
            r_start <= 1'b1;
            r_stop  <= c_single;
            r_data  <= w_offset;
          end
        end

        S_RUN: begin
          if (w_cancel || (w_transfer && w_last)) begin
            // Abort or frame complete: return to IDLE with a quiet bus.
            // The mandatory IDLE cycle gives the one-cycle gap between
            // back-to-back frames.
            r_state <= S_IDLE;
            r_p     <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_data  <= '0;
          end else if (w_transfer) begin
            r_p     <= r_p + c_pw'(1);
            r_data  <= w_next_data;
            r_start <= 1'b0;
            r_stop  <= (r_p == c_penult);
          end
          // Ready low: every output holds.
        end

        default: begin
          r_state <= S_IDLE;
          r_p     <= '0;
          r_valid <= 1'b0;
          r_start <= 1'b0;
          r_stop  <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_image_test_pattern.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_test_pattern
// Purpose  : Directed self-checking bench for image_test_pattern. Three
//            instances: 4x2 frame (8-bit data), 1x1 frame (8-bit data) and a
//            3x2 frame with 2-bit data for wrap-around.
// Revision : 1.0 - initial release
// ============================================================================

module tb_image_test_pattern;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IMAGE_TEST_PATTERN_FRAME_COUNT_EN
  localparam int FC = 1;
`else
  localparam int FC = 0;
`endif

  // Bus layout: [0] Start [1] Stop [2] Valid [3] Error [4] Ready [5] Request
  //             [6] Cancel [7 +: DW] Data
  wire  [14:0] bus_a;
  wire  [14:0] bus_b;
  wire  [8:0]  bus_c;
  logic a_ready = 1'b1, a_req = 1'b0, a_cancel = 1'b0;
  logic b_ready = 1'b1, b_req = 1'b0, b_cancel = 1'b0;
  logic c_ready = 1'b1, c_req = 1'b0, c_cancel = 1'b0;

  assign bus_a[4] = a_ready;
  assign bus_a[5] = a_req;
  assign bus_a[6] = a_cancel;
  assign bus_b[4] = b_ready;
  assign bus_b[5] = b_req;
  assign bus_b[6] = b_cancel;
  assign bus_c[4] = c_ready;
  assign bus_c[5] = c_req;
  assign bus_c[6] = c_cancel;

  // Observed vectors: {valid, start, stop, error, data}
  wire [11:0] a_obs = {bus_a[2], bus_a[0], bus_a[1], bus_a[3], bus_a[14:7]};
  wire [11:0] b_obs = {bus_b[2], bus_b[0], bus_b[1], bus_b[3], bus_b[14:7]};
  wire [5:0]  c_obs = {bus_c[2], bus_c[0], bus_c[1], bus_c[3], bus_c[8:7]};

  image_test_pattern #(.OutIS(8), .Width(4), .Height(2)) dut_a (
    .clock(clk), .reset(rst_n), .image_out(bus_a)
  );
  image_test_pattern #(.OutIS(8), .Width(1), .Height(1)) dut_b (
    .clock(clk), .reset(rst_n), .image_out(bus_b)
  );
  image_test_pattern #(.OutIS(2), .Width(3), .Height(2)) dut_c (
    .clock(clk), .reset(rst_n), .image_out(bus_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    a_req = 1'b0; a_cancel = 1'b0; a_ready = 1'b1;
    b_req = 1'b0; b_cancel = 1'b0; b_ready = 1'b1;
    c_req = 1'b0; c_cancel = 1'b0; c_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL reset_a: got %h want %h", a_obs, 12'h000);
    end
    n_checks++;
    if (b_obs !== 12'h000) begin
      n_errors++; $display("FAIL reset_b: got %h want %h", b_obs, 12'h000);
    end
    n_checks++;
    if (c_obs !== 6'h00) begin
      n_errors++; $display("FAIL reset_c: got %h want %h", c_obs, 6'h00);
    end
  endtask

  task automatic test_single_frame;
    logic [11:0] exp;
    do_reset;
    a_req = 1'b1;
    tick;
    a_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), 1'b0, 8'(i)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL single_frame px%0d: got %h want %h", i, a_obs, exp);
      end
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (a_obs !== 12'h000) begin
        n_errors++; $display("FAIL single_frame idle%0d: got %h want %h", k, a_obs, 12'h000);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] exp;
    do_reset;
    a_req = 1'b1;
    tick;
    a_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), 1'b0, 8'(i)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL backpressure px%0d: got %h want %h", i, a_obs, exp);
      end
      if (i == 3) begin
        a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick;
          n_checks++;
          if (a_obs !== exp) begin
            n_errors++; $display("FAIL backpressure hold%0d: got %h want %h", k, a_obs, exp);
          end
        end
        a_ready = 1'b1;
      end
      tick;
    end
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL backpressure end: got %h want %h", a_obs, 12'h000);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp;
    do_reset;
    a_req = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), 1'b0, 8'(i)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL back_to_back f0 px%0d: got %h want %h", i, a_obs, exp);
      end
      tick;
    end
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL back_to_back gap: got %h want %h", a_obs, 12'h000);
    end
    tick;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) a_req = 1'b0;
      exp = {1'b1, (i == 0), (i == 7), 1'b0, 8'(i + FC)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL back_to_back f1 px%0d: got %h want %h", i, a_obs, exp);
      end
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (a_obs !== 12'h000) begin
        n_errors++; $display("FAIL back_to_back idle%0d: got %h want %h", k, a_obs, 12'h000);
      end
      tick;
    end
  endtask

  task automatic test_cancel;
    logic [11:0] exp;
    do_reset;
    a_req = 1'b1;
    tick;
    a_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, (i == 0), 1'b0, 1'b0, 8'(i)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL cancel px%0d: got %h want %h", i, a_obs, exp);
      end
      if (i < 5) tick;
    end
    a_cancel = 1'b1;
    tick;
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL cancel abort: got %h want %h", a_obs, 12'h000);
    end
    // Cancel in IDLE must block a requested start.
    a_req = 1'b1;
    tick;
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL cancel idle_block: got %h want %h", a_obs, 12'h000);
    end
    a_cancel = 1'b0;
    tick;
    a_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), 1'b0, 8'(i)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL cancel restart px%0d: got %h want %h", i, a_obs, exp);
      end
      tick;
    end
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL cancel end: got %h want %h", a_obs, 12'h000);
    end
  endtask

  task automatic test_async_reset;
    logic [11:0] exp;
    do_reset;
    a_req = 1'b1;
    tick;
    a_req = 1'b0;
    tick;
    tick;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    n_checks++;
    if (a_obs !== exp) begin
      n_errors++; $display("FAIL async_reset px2: got %h want %h", a_obs, exp);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL async_reset immediate: got %h want %h", a_obs, 12'h000);
    end
    a_req = 1'b1;
    tick;
    n_checks++;
    if (a_obs !== 12'h000) begin
      n_errors++; $display("FAIL async_reset held: got %h want %h", a_obs, 12'h000);
    end
    rst_n = 1'b1;
    tick;
    a_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, (i == 0), (i == 7), 1'b0, 8'(i)};
      n_checks++;
      if (a_obs !== exp) begin
        n_errors++; $display("FAIL async_reset fresh px%0d: got %h want %h", i, a_obs, exp);
      end
      tick;
    end
  endtask

  task automatic test_one_pixel;
    logic [11:0] exp;
    do_reset;
    b_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      exp = {1'b1, 1'b1, 1'b1, 1'b0, 8'(k * FC)};
      n_checks++;
      if (b_obs !== exp) begin
        n_errors++; $display("FAIL one_pixel f%0d: got %h want %h", k, b_obs, exp);
      end
      tick;
      n_checks++;
      if (b_obs !== 12'h000) begin
        n_errors++; $display("FAIL one_pixel gap%0d: got %h want %h", k, b_obs, 12'h000);
      end
    end
    b_req = 1'b0;
    tick;
    n_checks++;
    if (b_obs !== 12'h000) begin
      n_errors++; $display("FAIL one_pixel stop: got %h want %h", b_obs, 12'h000);
    end
  endtask

  task automatic test_wrap;
    logic [5:0] exp;
    do_reset;
    c_req = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, (i == 0), (i == 5), 1'b0, 2'(i)};
      n_checks++;
      if (c_obs !== exp) begin
        n_errors++; $display("FAIL wrap f0 px%0d: got %h want %h", i, c_obs, exp);
      end
      tick;
    end
    n_checks++;
    if (c_obs !== 6'h00) begin
      n_errors++; $display("FAIL wrap gap: got %h want %h", c_obs, 6'h00);
    end
    tick;
    c_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, (i == 0), (i == 5), 1'b0, 2'(i + FC)};
      n_checks++;
      if (c_obs !== exp) begin
        n_errors++; $display("FAIL wrap f1 px%0d: got %h want %h", i, c_obs, exp);
      end
      tick;
    end
    n_checks++;
    if (c_obs !== 6'h00) begin
      n_errors++; $display("FAIL wrap end: got %h want %h", c_obs, 6'h00);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_backpressure;
    test_back_to_back;
    test_cancel;
    test_async_reset;
    test_one_pixel;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
